// File: rtl/z_result_buffer_pkg.sv
// Shared types and constants for the ALU result buffer.
// Entry layout is fixed at DW_DEFAULT bits per half.
package z_result_buffer_pkg;

    localparam int DW_DEFAULT = 32;
    localparam int REG_IDX_W  = 4;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] lo;
        logic [DW_DEFAULT-1:0] hi;
        logic [REG_IDX_W-1:0]  dest;
        logic                  wide;
        logic                  zero;
        logic                  neg;
    } z_entry_t;

endpackage

// File: rtl/z_result_buffer_flag.sv
// z_flag_gen: zero/negative flags of a result, which is either the
// low word alone or the full {hi,lo} pair.
module z_flag_gen #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] lo,
    input  logic [DW-1:0] hi,
    input  logic          wide,
    output logic          zero,
    output logic          neg
);

    always_comb begin
        zero = wide ? ({hi, lo} == '0) : (lo == '0);
        neg  = wide ? hi[DW-1] : lo[DW-1];
    end

endmodule

// File: rtl/z_result_buffer.sv
// FIFO of ALU results with precomputed zero/neg flags. No bypass:
// a full buffer refuses pushes even while it is popping.
module z_result_buffer
    import z_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [DW-1:0]            resultLo,
    input  logic [DW-1:0]            resultHi,
    input  logic                     in_wide,
    input  logic [REG_IDX_W-1:0]     in_dest,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            zlo,
    output logic [DW-1:0]            zhi,
    output logic [REG_IDX_W-1:0]     z_dest,
    output logic                     z_wide,
    output logic                     z_zero,
    output logic                     z_neg,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    z_entry_t        mem [DEPTH];
    z_entry_t        wr_entry;
    z_entry_t        head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            flag_zero;
    logic            flag_neg;

    z_flag_gen #(.DW(DW)) u_flag (
        .lo   (resultLo),
        .hi   (resultHi),
        .wide (in_wide),
        .zero (flag_zero),
        .neg  (flag_neg)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Halves are sized into the fixed-width package entry.
    always_comb begin
        wr_entry      = '0;
        wr_entry.lo   = DW_DEFAULT'(resultLo);
        wr_entry.hi   = in_wide ? DW_DEFAULT'(resultHi) : '0;
        wr_entry.dest = in_dest;
        wr_entry.wide = in_wide;
        wr_entry.zero = flag_zero;
        wr_entry.neg  = flag_neg;
    end

    // Storage is left uncleared by reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && !in_ready) overrun <= 1'b1;
        end
    end

    always_comb begin
        head   = mem[rd_ptr];
        zlo    = '0;
        zhi    = '0;
        z_dest = '0;
        z_wide = 1'b0;
        z_zero = 1'b0;
        z_neg  = 1'b0;
        if (out_valid) begin
            zlo    = DW'(head.lo);
            zhi    = DW'(head.hi);
            z_dest = head.dest;
            z_wide = head.wide;
            z_zero = head.zero;
            z_neg  = head.neg;
        end
    end

endmodule

// File: doc/z_result_buffer.md
Z_RESULT_BUFFER -- requirements
Module: z_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter DW, default 32, width of each result half.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 clr  in  1  reset, asynchronous, active-low; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 resultLo  in  DW  ALU low result word (quotient for DIV).
REQ-006 resultHi  in  DW  ALU high result word (MUL high, DIV remainder).
REQ-007 in_wide  in  1  result is 64-bit (MUL/DIV); hi half is meaningful.
REQ-008 in_dest  in  4  destination register index.
REQ-009 in_valid  in  1  producer offers a result this cycle.
REQ-010 in_ready  out  1  buffer accepts a result this cycle.
REQ-011 zlo, zhi  out  DW each  head-entry result halves.
REQ-012 z_dest  out  4; z_wide  out  1  head-entry tags.
REQ-013 z_zero, z_neg  out  1 each  head-entry flags.
REQ-014 out_valid  out  1  head entry present; out_ready  in  1  consumer takes head.
REQ-015 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-016 overrun  out  1  sticky error flag.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH); with no bypass, a full buffer refuses a push even when a pop occurs in the same cycle.
REQ-019 On push, the entry SHALL store resultLo, in_wide, in_dest, and resultHi when in_wide=1, otherwise 0.
REQ-020 On push, zero SHALL be computed and stored as ({resultHi,resultLo}==0) when wide, otherwise (resultLo==0).
REQ-021 On push, neg SHALL be computed and stored as resultHi[DW-1] when wide, otherwise resultLo[DW-1].
REQ-022 Latency: a push into an empty buffer SHALL raise out_valid on the following cycle; there is no same-cycle passthrough.
REQ-023 Order SHALL be strictly FIFO; write and read pointers SHALL wrap modulo DEPTH.
REQ-024 Simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-025 While out_valid=0, zlo, zhi, z_dest, z_wide, z_zero and z_neg SHALL be driven to 0.
REQ-026 Head outputs SHALL remain stable while out_valid && !out_ready.
REQ-027 in_valid while in_ready=0 SHALL set overrun, which holds until reset, and SHALL NOT alter stored data.
REQ-028 out_ready while out_valid=0 SHALL be ignored; count SHALL NOT underflow.

Reset
REQ-029 clr=0 SHALL asynchronously clear pointers, count, and overrun.
REQ-030 During reset, out_valid SHALL be 0, in_ready SHALL be 1, and all head outputs SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-032 The first push SHALL be accepted on the first rising edge after clr deasserts.

Structure
REQ-033 A shared package SHALL hold the entry struct {lo, hi, dest, wide, zero, neg}, DW default, and the register-index width constant.
REQ-034 The flag computation SHALL be one sub-module, z_flag_gen (combinational, inputs lo/hi/wide, outputs zero/neg); storage and pointer logic SHALL stay in z_result_buffer.

Verification
REQ-035 Reset, then push lo=0x0000_0005, wide=0, dest=3 with out_ready=0 -> next cycle out_valid=1, zlo=5, zhi=0, z_zero=0, z_neg=0, count=1.
REQ-036 Push wide lo=0, hi=0x8000_0000 -> z_neg=1, z_zero=0; push wide lo=0, hi=0 -> z_zero=1; push non-wide lo=0, hi=0xFFFF_FFFF -> zhi=0, z_zero=1.
REQ-037 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid -> overrun=1 and the 5th entry is absent when the buffer is drained.
REQ-038 Full buffer, in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, count=3; the next cycle accepts the push.
REQ-039 Stream 10 entries with out_ready toggling on every cycle -> output sequence equals input sequence across pointer wrap, and count returns to 0.
REQ-040 With 2 entries held, pulse clr low between clock edges -> out_valid=0, count=0 and overrun=0 immediately, before the next clk edge.
